// File: rtl/audipus_audio_pkg.sv
// audipus_audio_pkg: shared audio widths, I2S framing constants and sample conditioning
package audipus_audio_pkg;
    localparam int AUD_DIN_W      = 32;
    localparam int AUD_DOUT_W     = 24;
    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;
    localparam int MCLK_FS_RATIO  = 512;

    localparam logic signed [AUD_DIN_W-1:0] SAT_MAX = AUD_DIN_W'(2 ** (AUD_DOUT_W - 1) - 1);
    localparam logic signed [AUD_DIN_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic [AUD_DOUT_W-1:0] sat_shift(input logic signed [AUD_DIN_W-1:0] din, input int shift);
        logic signed [AUD_DIN_W-1:0] s;
        s = din >>> shift;
        return s > SAT_MAX ? {1'b0, {(AUD_DOUT_W-1){1'b1}}} :
               s < SAT_MIN ? {1'b1, {(AUD_DOUT_W-1){1'b0}}} : s[AUD_DOUT_W-1:0];
    endfunction
endpackage

// File: rtl/i2s_dac_tx_clk_gen.sv
// i2s_clk_gen: derives bclk/lrclk from clk and flags the bclk fall and frame-load events
module i2s_clk_gen #(
    parameter int BCLK_DIV = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    output logic       bclk,
    output logic       lrclk,
    output logic       fall_evt,
    output logic       frame_load,
    output logic [5:0] bit_nxt
);
    localparam int DW = $clog2(BCLK_DIV);

    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic          primed;

    // the first fall after run rises opens a frame at slot 0 rather than advancing
    always_comb begin
        fall_evt   = run && div_cnt == DW'(BCLK_DIV - 1);
        bit_nxt    = primed ? bit_cnt + 6'd1 : 6'd0;
        frame_load = fall_evt && bit_nxt == 6'd0;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            primed  <= 1'b0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            primed  <= 1'b0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
        end else begin
            div_cnt <= fall_evt ? '0 : div_cnt + DW'(1);
            if (div_cnt == DW'(BCLK_DIV / 2 - 1))
                bclk <= 1'b1;
            if (fall_evt) begin
                bclk    <= 1'b0;
                bit_cnt <= bit_nxt;
                lrclk   <= bit_nxt[5];
                primed  <= 1'b1;
            end
        end
endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: conditions stereo samples to 24 bits and serialises them as Philips I2S
module i2s_dac_tx
    import audipus_audio_pkg::*;
#(
    parameter int DIN_W    = AUD_DIN_W,
    parameter int DOUT_W   = AUD_DOUT_W,
    parameter int SHIFT    = 9,
    parameter int BCLK_DIV = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             din_valid,
    input  logic [DIN_W-1:0] l_data_in,
    input  logic [DIN_W-1:0] r_data_in,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun,
    output logic             overrun
);
    localparam int PAD = I2S_SLOT_BITS - DOUT_W;

    logic                     fall_evt, frame_load;
    logic [5:0]               bit_nxt;
    logic [DOUT_W-1:0]        pend_l, pend_r, frame_l, frame_r;
    logic                     pend_valid;
    logic [I2S_SLOT_BITS-1:0] shreg, shreg_next;

    i2s_clk_gen #(.BCLK_DIV(BCLK_DIV)) u_clk_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .fall_evt   (fall_evt),
        .frame_load (frame_load),
        .bit_nxt    (bit_nxt)
    );

    // a load in the same cycle as din_valid consumes the old entry, so it is not an overrun
    always_comb begin
        underrun   = frame_load && !pend_valid;
        overrun    = run && din_valid && pend_valid && !frame_load;
        shreg_next = bit_nxt == 6'd1  ? {frame_l, {PAD{1'b0}}} :
                     bit_nxt == 6'd33 ? {frame_r, {PAD{1'b0}}} : {shreg[I2S_SLOT_BITS-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pend_l     <= '0;
            pend_r     <= '0;
            pend_valid <= 1'b0;
            frame_l    <= '0;
            frame_r    <= '0;
            shreg      <= '0;
            sdata      <= 1'b0;
        end else if (!run) begin
            pend_l     <= '0;
            pend_r     <= '0;
            pend_valid <= 1'b0;
            frame_l    <= '0;
            frame_r    <= '0;
            shreg      <= '0;
            sdata      <= 1'b0;
        end else begin
            if (frame_load) begin
                frame_l <= pend_valid ? pend_l : '0;
                frame_r <= pend_valid ? pend_r : '0;
            end
            if (din_valid) begin
                pend_l     <= sat_shift(l_data_in, SHIFT);
                pend_r     <= sat_shift(r_data_in, SHIFT);
                pend_valid <= 1'b1;
            end else if (frame_load)
                pend_valid <= 1'b0;
            if (fall_evt) begin
                shreg <= shreg_next;
                sdata <= shreg_next[I2S_SLOT_BITS-1];
            end
        end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: directed I2S transmitter bench with a frame scoreboard fed by the stimulus
module tb_i2s_dac_tx;
    logic        clk = 0, reset_n = 0, run = 1, din_valid = 0;
    logic [31:0] l_data_in = 0, r_data_in = 0;
    logic        bclk, lrclk, sdata, underrun, overrun;

    i2s_dac_tx dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .din_valid (din_valid),
        .l_data_in (l_data_in),
        .r_data_in (r_data_in),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .underrun  (underrun),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, ur_cnt = 0, ov_cnt = 0, ur_cyc = 0, fall_cnt = 0, fall_cyc = 0, frm_cnt = 0;
    int idx = 0, rise_cyc = 0, lr_rise = 0, prev_fall = 0, c0 = 0;
    logic        bclk_q = 0, lr_q = 0, plr = 1, armed = 0, pad = 0;
    logic [23:0] word = 0, got_l = 0;
    logic [47:0] exp_f;
    logic [47:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // floor division by 512 then clamp to the signed 24-bit range
    function automatic logic [23:0] model(input logic [31:0] x);
        longint v, q;
        v = longint'($signed(x));
        q = v / 512;
        if (v < 0 && v % 512 != 0) q = q - 1;
        if (q > 8388607) q = 8388607;
        if (q < -8388608) q = -8388608;
        return q[23:0];
    endfunction

    // I2S receiver: sample sdata on bclk rises, slot index restarts at each lrclk edge
    always @(negedge clk) begin
        cyc++;
        if (underrun === 1'b1) begin ur_cnt++; ur_cyc = cyc; end
        if (overrun === 1'b1) ov_cnt++;
        if (!run || !reset_n) begin
            armed = 0; plr = 1; prev_fall = 0; rise_cyc = 0;
        end else begin
            if (bclk_q && !bclk) armed = 1;
            if (armed && bclk && !bclk_q) begin
                if (rise_cyc != 0) chk("bclk_period", cyc - rise_cyc, 8);
                rise_cyc = cyc;
                idx = (lrclk !== plr) ? 0 : idx + 1;
                plr = lrclk;
                if (idx == 0) begin word = 0; pad = sdata; end
                else if (idx <= 24) word = {word[22:0], sdata};
                else pad = pad | sdata;
                if (idx == 31) chk("pad_zero", pad, 0);
                if (idx == 24 && !lrclk) got_l = word;
                if (idx == 24 && lrclk) begin
                    frm_cnt++;
                    if (sb.size() == 0) chk("sb_has_entry", sb.size() != 0, 1);
                    else begin
                        exp_f = sb.pop_front();
                        chk("frame", {got_l, word}, exp_f);
                    end
                end
            end
            if (armed && lrclk && !lr_q) lr_rise = cyc;
            if (armed && !lrclk && lr_q) begin
                fall_cnt++;
                fall_cyc = cyc;
                if (prev_fall != 0) begin
                    chk("lr_period", cyc - prev_fall, 512);
                    chk("lr_high", cyc - lr_rise, 256);
                end
                prev_fall = cyc;
            end
        end
        lr_q = lrclk;
        bclk_q = bclk;
    end

    task automatic drive(input logic [31:0] l, input logic [31:0] r, input bit push);
        @(negedge clk);
        din_valid = 1; l_data_in = l; r_data_in = r;
        @(negedge clk);
        din_valid = 0;
        #1;
        if (push) sb.push_back({model(l), model(r)});
    endtask

    task automatic wait_rel(input int n);
        for (int i = 0; i < 600 && cyc != fall_cyc + n; i++) begin @(negedge clk); #1; end
    endtask

    task automatic drive_at_load(input logic [31:0] l, input logic [31:0] r);
        wait_rel(511);
        din_valid = 1; l_data_in = l; r_data_in = r;
        @(negedge clk);
        din_valid = 0;
        #1;
        sb.push_back({model(l), model(r)});
    endtask

    task automatic next_frame;
        int start;
        bit seen;
        start = fall_cnt;
        seen = 0;
        for (int i = 0; i < 700 && !seen; i++) begin @(negedge clk); #1; seen = fall_cnt != start; end
        chk("frame_start", seen, 1);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        #1;
        chk("rst_bclk", bclk, 0);
        chk("rst_lrclk", lrclk, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_overrun", overrun, 0);
        sb.push_back(48'h0);
        reset_n = 1;
        c0 = cyc;
        repeat (20) @(negedge clk);
        #1;
        chk("start_ur_cnt", ur_cnt, 1);
        chk("start_ur_cyc", ur_cyc, c0 + 7);
        drive(32'h0000_0200, 32'hFFFF_FE00, 1);
        next_frame();
        drive(32'h7FFF_FFFF, 32'h8000_0000, 1);
        next_frame();
        drive(32'h00FF_FE00, 32'hEDCB_A987, 1);
        next_frame();
        chk("steady_ur", ur_cnt, 1);
        chk("steady_ov", ov_cnt, 0);
        sb.push_back(48'h0);
        next_frame();
        chk("starve_ur", ur_cnt, 2);
        chk("starve_ur_cyc", ur_cyc, fall_cyc - 1);
        sb.push_back(48'h0);
        drive_at_load(32'h1234_5678, 32'h8765_4321);
        chk("coinc_empty_ur", ur_cnt, 3);
        chk("coinc_empty_ov", ov_cnt, 0);
        next_frame();
        drive(32'h1111_1111, 32'h2222_2222, 0);
        repeat (8) @(negedge clk);
        drive(32'h00FF_FE00, 32'hFF00_0000, 1);
        chk("overrun_once", ov_cnt, 1);
        next_frame();
        drive(32'hFFFF_FFFF, 32'h4000_0000, 1);
        drive_at_load(32'h0ABC_DE00, 32'hF0F0_F0F0);
        chk("coinc_full_ov", ov_cnt, 1);
        chk("coinc_full_ur", ur_cnt, 3);
        next_frame();
        next_frame();
        chk("drop_frame_ur", ur_cnt, 4);
        wait_rel(324);
        chk("slot40_lrclk", lrclk, 1);
        run = 0;
        @(negedge clk);
        #1;
        chk("stop_bclk", bclk, 0);
        chk("stop_lrclk", lrclk, 0);
        chk("stop_sdata", sdata, 0);
        chk("stop_underrun", underrun, 0);
        chk("stop_overrun", overrun, 0);
        drive(32'h5555_5555, 32'h3333_3333, 0);
        repeat (30) @(negedge clk);
        chk("stopped_ov", ov_cnt, 1);
        @(negedge clk);
        #1;
        run = 1;
        c0 = cyc;
        sb.push_back(48'h0);
        repeat (20) @(negedge clk);
        #1;
        chk("restart_ur", ur_cnt, 5);
        chk("restart_ur_cyc", ur_cyc, c0 + 7);
        drive(32'h0000_0200, 32'h0000_0400, 1);
        next_frame();
        next_frame();
        chk("final_ur", ur_cnt, 6);
        chk("final_ov", ov_cnt, 1);
        chk("sb_drained", sb.size(), 0);
        chk("frames_seen", frm_cnt, 12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
